wb_regfile: RTL
===============

# wb_regfile

Writeback-stage consumer of the MEM/WB pipeline register, merged with the architectural integer register file. It selects and load-extends the final result, then commits it to a 32 x 32-bit register file. It serves the two decode-stage read ports and counts retired instructions. It is the reader end of the W-stage control bundle (RegWriteW, ResultSrcW, funct3W).

## Interface
- XLEN, 32, data width of registers, results and read ports
- CNT_W, 64, width of retired-instruction counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- RegWriteW  in  1  commit ResultW to RdW this cycle
- ResultSrcW  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 immediate
- funct3W  in  3  load width/sign for ResultSrcW=01
- ValidW  in  1  a real (non-bubble) instruction occupies W this cycle
- RdW  in  5  destination register index
- ALUResultW  in  XLEN  ALU result; bits [1:0] are the load byte offset
- ReadDataW  in  XLEN  raw aligned memory word
- PCPlus4W  in  XLEN  link value for JAL/JALR
- ImmExtW  in  XLEN  immediate for LUI
- Rs1D, Rs2D  in  5 each  decode-stage read indices
- RD1D, RD2D  out  XLEN each  read data, combinational
- ResultW  out  XLEN  selected, extended result; also drives forwarding
- InstRetW  out  CNT_W  retired-instruction count

## Operation
- Result mux: 00 -> ALUResultW, 01 -> extended load, 10 -> PCPlus4W, 11 -> ImmExtW.
- Load extraction: byte lane = ALUResultW[1:0]; halfword lane = ALUResultW[1].
  - funct3 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 011/110/111: full word, no trap.
- Misaligned LH/LW are not checked. LH uses lane ALUResultW[1]. LW ignores the offset.
- Write: at the rising edge, if RegWriteW=1 and RdW!=0, regs[RdW] <= ResultW.
  - Writes to x0 are discarded.
  - RD for index 0 is always 0.
- Reads: RD1D = regs[Rs1D] and RD2D = regs[Rs2D], combinational.
- Retire counter: at the rising edge, InstRetW <= InstRetW + 1 when ValidW=1, independent of RegWriteW.
  - Wraps modulo 2^CNT_W with no saturation and no flag.
- ResultW is combinational and valid whenever the inputs are. It does not depend on RegWriteW.

## Timing
- Reset (asynchronous, active-high) forces regs[1..31]=0 and InstRetW=0 immediately.
- While reset is high: RD1D=RD2D=0 and no write or count occurs.
- Reset mid-operation discards any same-cycle commit and any same-cycle count. Reset wins over every edge event.
- ResultW has no reset value; it follows the inputs.
- Write latency: 1 edge. A value written at edge N is readable through the array after edge N.
- Same-cycle read/write of the same nonzero index is governed by the configuration macro.
- Both read ports may address the same register or the written register simultaneously. Each port resolves independently.
- Counter after edge N equals the number of cycles with ValidW=1 since reset deassertion, mod 2^CNT_W.

## Configuration
- WB_REGFILE_BYPASS_EN defined:
  - If RegWriteW=1, RdW!=0 and RdW==Rs1D, then RD1D=ResultW in the same cycle; likewise for Rs2D/RD2D.
  - Decode sees the W-stage value with zero stall. The hazard unit does not need WB->D forwarding.
- Not defined:
  - RD1D/RD2D return the stored array value, i.e. the pre-write value during a same-cycle write.
  - The hazard unit must stall or forward for WB->D dependencies.

## Test plan
- Reset then read: pulse reset with regs preloaded -> RD1D=RD2D=0 for all Rs indices 0..31, InstRetW=0.
- Load extension: ReadDataW=0x80F0_7F81, ResultSrcW=01, RegWriteW=1, RdW=5.
  - LB offset 0 -> x5=0xFFFF_FF81.
  - LBU offset 3 -> 0x0000_0080.
  - LH offset 2 -> 0xFFFF_80F0.
  - LHU offset 0 -> 0x0000_7F81.
  - LW -> 0x80F0_7F81.
- x0 immunity: RegWriteW=1, RdW=0, ALU result 0xDEAD_BEEF -> Rs1D=0 reads 0 next cycle; no other register changes.
- Same-cycle bypass: x7=0x11 stored; write 0x22 to x7 with Rs1D=Rs2D=7.
  - With WB_REGFILE_BYPASS_EN: both ports read 0x22 that cycle.
  - Without the macro: both read 0x11 that cycle and 0x22 the next.
- Result mux: ResultSrcW 10 with PCPlus4W=0x104 and 11 with ImmExtW=0x1234_5000 into x1/x2 -> reads 0x104 and 0x1234_5000.
- Counter: 10 cycles with ValidW pattern 1101101101 -> InstRetW=7.
  - Preload near 2^64-1 with 2 valids -> wraps to 0.
  - Assert reset mid-stream -> 0 immediately.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage merged with the 32 x XLEN integer register file and retired-instruction counter.
// Optional WB_REGFILE_BYPASS_EN: same-cycle write-to-read bypass on both decode read ports.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcW,
  input  logic [2:0]       funct3W,
  input  logic             ValidW,
  input  logic [4:0]       RdW,
  input  logic [XLEN-1:0]  ALUResultW,
  input  logic [XLEN-1:0]  ReadDataW,
  input  logic [XLEN-1:0]  PCPlus4W,
  input  logic [XLEN-1:0]  ImmExtW,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  output logic [XLEN-1:0]  RD1D,
  output logic [XLEN-1:0]  RD2D,
  output logic [XLEN-1:0]  ResultW,
  output logic [CNT_W-1:0] InstRetW
);

  logic [XLEN-1:0]  regs_r [32];
  logic [CNT_W-1:0] instret_r;
  logic [XLEN-1:0]  result_s;
  logic [XLEN-1:0]  rd1_s;
  logic [XLEN-1:0]  rd2_s;
  logic             commit_s;

  // Misaligned halfword/word accesses are deliberately not trapped.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                  input logic [1:0] off,
                                                  input logic [XLEN-1:0] word);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] val;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  val = {{(XLEN-8){b[7]}}, b};
      3'b001:  val = {{(XLEN-16){h[15]}}, h};
      3'b100:  val = {{(XLEN-8){1'b0}}, b};
      3'b101:  val = {{(XLEN-16){1'b0}}, h};
      default: val = word;
    endcase
    return val;
  endfunction

  // Final result select; independent of RegWriteW so it can feed forwarding.
  always_comb begin
    result_s = {XLEN{1'b0}};
    case (ResultSrcW)
      2'b00:   result_s = ALUResultW;
      2'b01:   result_s = load_extend(funct3W, ALUResultW[1:0], ReadDataW);
      2'b10:   result_s = PCPlus4W;
      2'b11:   result_s = ImmExtW;
      default: result_s = ALUResultW;
    endcase
  end

  assign commit_s = RegWriteW && (RdW != 5'd0);

  // Read port 1: x0 and reset force zero.
  always_comb begin
    rd1_s = {XLEN{1'b0}};
    if (reset || (Rs1D == 5'd0)) begin
      rd1_s = {XLEN{1'b0}};
`ifdef WB_REGFILE_BYPASS_EN
    end else if (commit_s && (RdW == Rs1D)) begin
      rd1_s = result_s;
`endif
    end else begin
      rd1_s = regs_r[Rs1D];
    end
  end

  // Read port 2: resolved independently of port 1.
  always_comb begin
    rd2_s = {XLEN{1'b0}};
    if (reset || (Rs2D == 5'd0)) begin
      rd2_s = {XLEN{1'b0}};
`ifdef WB_REGFILE_BYPASS_EN
    end else if (commit_s && (RdW == Rs2D)) begin
      rd2_s = result_s;
`endif
    end else begin
      rd2_s = regs_r[Rs2D];
    end
  end

  // Register array commit; entry 0 is never written and stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (commit_s) begin
      regs_r[RdW] <= result_s;
    end else begin
      regs_r[RdW] <= regs_r[RdW];
    end
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_r <= {CNT_W{1'b0}};
    end else if (ValidW) begin
      instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_r <= instret_r;
    end
  end

  assign ResultW  = result_s;
  assign RD1D     = rd1_s;
  assign RD2D     = rd2_s;
  assign InstRetW = instret_r;

endmodule
